fifo_rd_stream: RTL

- Read-side consumer of the async FIFO, entirely in the read clock domain.
- Drains words by driving the FIFO's r_inc whenever rempty is low and buffer space exists, and absorbs the FIFO memory read latency.
- Presents words on a valid/ready stream (m_*) to the downstream datapath, with a 2-entry output buffer so back-pressure never loses a word.
- Also provides enable/flush control and a popped-word counter for the UVM scoreboard.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_rd_stream_if.sv | 29 ++
 rtl/fifo_rd_skid.sv | 66 ++++++
 rtl/fifo_rd_stream.sv | 117 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the async-FIFO read-side stream block.
// No logic; pure declarations plus one helper for the pop-space check.
// Imported by the interface, the skid buffer and the top.
package fifo_pkg;

  localparam int DATASIZE_DEFAULT = 8;
  localparam int SKID_DEPTH       = 2;

  typedef logic [DATASIZE_DEFAULT-1:0] data_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } rd_state_e;

  // True when a new pop still fits: words already buffered plus words in
  // flight, minus the one leaving this cycle, must leave room for one more.
  // deq is only ever set with occ != 0, so the subtraction cannot underflow.
  function automatic logic has_space(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       deq);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
    return committed < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream of the FIFO read side, plus buffer level.
// Combinational bundle; no latency of its own.
// m_ready from the slave is the only backpressure signal.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEFAULT
) ();

  logic                m_valid;
  logic                m_ready;
  logic [DATASIZE-1:0] m_data;
  logic [1:0]          m_level;

  modport master (
    output m_valid,
    output m_data,
    output m_level,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_level,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry circular output buffer with push, pop and synchronous flush.
// Latency: a push is visible at head_dat/occ the cycle after the push edge.
// Backpressure: caller must not push when full without a same-cycle pop.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEFAULT
) (
  input  logic                core_clk,
  input  logic                arst_n,
  input  logic                push_vld,
  input  logic [DATASIZE-1:0] push_dat,
  input  logic                pop_rdy,
  input  logic                flush,
  output logic [DATASIZE-1:0] head_dat,
  output logic [1:0]          occ
);

  logic [DATASIZE-1:0] entry_q [SKID_DEPTH];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          occ_q;

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_vld) wr_ptr_q <= ~wr_ptr_q;
      if (pop_rdy)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_vld, pop_rdy})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Data store; a push that coincides with flush is dropped.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) entry_q[i] <= '0;
    end else if (push_vld && !flush) begin
      entry_q[wr_ptr_q] <= push_dat;
    end
  end

  assign head_dat = entry_q[rd_ptr_q];
  assign occ      = occ_q;

  a_occ_range : assert property (@(posedge core_clk) disable iff (!arst_n)
    occ_q <= 2'(SKID_DEPTH));

  a_no_overflow : assert property (@(posedge core_clk) disable iff (!arst_n)
    !(push_vld && !pop_rdy && !flush && occ_q == 2'(SKID_DEPTH)));

  a_no_underflow : assert property (@(posedge core_clk) disable iff (!arst_n)
    !(pop_rdy && occ_q == 2'd0));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a 2-entry buffer and a valid/ready stream.
// Latency: first r_inc to m_valid is 1 cycle (RD_LAT=0) or 2 cycles (RD_LAT=1).
// Backpressure: m_ready low stops pops once buffered + in-flight words reach 2.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEFAULT,
  parameter int RD_LAT   = 0,
  parameter int CNTSIZE  = 16
) (
  input  logic                r_clk,
  input  logic                r_rst,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                r_inc,
  input  logic                en,
  input  logic                flush,
  fifo_rd_stream_if.master    m,
  output logic [CNTSIZE-1:0]  pop_count,
  output logic                busy
);

  logic [1:0]          occ;
  logic [DATASIZE-1:0] head_dat;
  logic                deq;
  logic                inflight;
  logic                cap_vld;
  logic                busy_w;
  logic                pop_en;
  rd_state_e           state_q;
  rd_state_e           state_d;
  logic [CNTSIZE-1:0]  pop_count_q;

  // Stream side: the buffer head is presented directly.
  assign m.m_valid = (occ != 2'd0);
  assign m.m_level = occ;
  assign m.m_data  = head_dat;
  assign deq       = m.m_valid & m.m_ready;

  // m_ready reaches r_inc combinationally so a full buffer can pop and refill
  // in the same cycle, sustaining one word per clock.
  assign r_inc = en & pop_en & ~rempty & ~flush & has_space(occ, inflight, deq);

  assign busy_w = (occ != 2'd0) | inflight;
  assign busy   = busy_w;

  if (RD_LAT == 0) begin : g_lat0
    // rdata is valid in the pop cycle itself, so capture alongside r_inc.
    assign inflight = 1'b0;
    assign cap_vld  = r_inc;
  end else begin : g_lat1
    logic vld_q;

    // One-deep in-flight marker; r_inc is already low during flush, so a
    // flush also drops whatever was in flight.
    always_ff @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= r_inc;
      end
    end

    assign inflight = vld_q;
    assign cap_vld  = vld_q;
  end

  fifo_rd_skid #(
    .DATASIZE (DATASIZE)
  ) u_skid (
    .core_clk (r_clk),
    .arst_n   (r_rst),
    .push_vld (cap_vld),
    .push_dat (rdata),
    .pop_rdy  (deq),
    .flush    (flush),
    .head_dat (head_dat),
    .occ      (occ)
  );

  // Control state register.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; pops are allowed in ACTIVE and on the cycle leaving IDLE.
  always_comb begin
    state_d = state_q;
    pop_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!en && !busy_w) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pop_en = (state_q == ACTIVE) || (state_d == ACTIVE);
  end

  // Counts every pop, including ones later discarded by flush.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      pop_count_q <= '0;
    end else if (r_inc) begin
      pop_count_q <= pop_count_q + CNTSIZE'(1);
    end
  end

  assign pop_count = pop_count_q;

endmodule
